ps2_keycode_decoder: RTL
========================

# ps2_keycode_decoder

Front-end keyboard stage that feeds the game processor. It receives raw PS/2 device-to-host frames on the keyboard clock and data lines, and assembles scan-code sequences (E0 extended prefix, F0 break prefix, E1 pause sequence). It presents each completed key event as the `keycode` / `key_make` / `key_ext` triple the processor latches on `en_key`, plus a one-cycle strobe.

## Interface
- `FILTER_LEN`, default 8: cycles `ps2_clk` must be stable before a level change is accepted (glitch filter).
- `TIMEOUT_CYCLES`, default 50000: maximum cycles between accepted falling edges inside a frame; 1 ms at 50 MHz.
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw keyboard clock pin, asynchronous.
- `ps2_dat`  in  1  raw keyboard data pin, asynchronous.
- `keycode`  out  8  last decoded scan code; held until the next event.
- `key_make`  out  1  1 = press, 0 = release for `keycode`; held.
- `key_ext`  out  1  1 = code was E0-prefixed; held.
- `key_strobe`  out  1  one-cycle pulse when `keycode` / `key_make` / `key_ext` update.
- `frame_err`  out  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
- Both pins pass through 2-flop synchronizers.
- `ps2_clk` is then glitch-filtered: the filtered level changes only after `FILTER_LEN` consecutive equal samples. A falling edge of the filtered clock is a "bit event".
- Frame FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: a bit event with `ps2_dat` = 0 (start bit) goes to DATA. A bit event with `ps2_dat` = 1 stays in IDLE and raises no error.
  - DATA: shifts 8 bits, LSB first, then goes to PARITY.
  - PARITY: checks odd parity over the 8 data bits and the parity bit.
  - STOP: requires `ps2_dat` = 1. A good frame yields `byte_valid`; otherwise `frame_err` pulses. Returns to IDLE either way.
- Timeout: in any state other than IDLE, a counter reloads on each bit event. Reaching `TIMEOUT_CYCLES` → `frame_err`, return to IDLE, discard partial byte and clear the sequence prefixes.
- Sequence FSM consumes `byte_valid`:
  - E0 sets `ext_pend`.
  - F0 sets `brk_pend`.
  - E1 enters PAUSE, which silently consumes the next 7 bytes and then emits keycode E1, make 1, ext 0.
  - Any other byte emits keycode = byte, `key_make` = !`brk_pend`, `key_ext` = `ext_pend`, then clears both pend flags.
- Any `frame_err` clears `ext_pend`, `brk_pend` and PAUSE. Held outputs remain unchanged.
- Host-to-device transmission is not supported; both pins are input only.

## Timing
- Reset values: `keycode` 0, `key_make` 0, `key_ext` 0, `key_strobe` 0, `frame_err` 0. Both FSMs in IDLE, pend flags 0, counters 0.
- Pin-to-bit-event latency: 2 synchronizer cycles + `FILTER_LEN` cycles.
- Bit event on the stop bit in cycle N → `keycode` / `key_make` / `key_ext` updated and `key_strobe` = 1 in cycle N+1. `frame_err` has the same N+1 timing.
- Outputs change only in the same cycle `key_strobe` = 1 and are held otherwise. The consumer may sample on the strobe or at any later cycle.
- Reset asserted mid-frame aborts immediately. After release, bit events are ignored until a start bit arrives in IDLE.
- A timeout expiring in the same cycle as a bit event: the bit event wins and the counter reloads.
- The timeout counter width is sized to hold `TIMEOUT_CYCLES`. The filter counter width is sized to hold `FILTER_LEN`. Parity is computed as the XOR of 9 bits, which must equal 1.

## Structure
- Package `ps2_pkg`:
  - byte constants `SC_EXT` = 8'hE0, `SC_BRK` = 8'hF0, `SC_PAUSE` = 8'hE1, and `PAUSE_TAIL_LEN` = 7;
  - frame-state and sequence-state enums.
- Sub-module `ps2_rx_frame`: synchronizers, filter, frame FSM and timeout. Outputs `byte`, `byte_valid` and `frame_err`.
- The top level holds the sequence FSM and the output registers.

## Test plan
- Frame 1C (start 0, data LSB-first, parity 0, stop 1) → one `key_strobe`; `keycode` 8'h1C, make 1, ext 0.
- F0, 1C → exactly one strobe, on the 1C byte; `keycode` 1C, make 0, ext 0.
- E0, 75 → `keycode` 75, make 1, ext 1. Then E0, F0, 75 → `keycode` 75, make 0, ext 1.
- 1C with parity bit flipped → `frame_err` pulse, no strobe, outputs hold previous values. A following good 29 → `keycode` 29, make 1.
- 4 bits of a frame, then `ps2_clk` held high for `TIMEOUT_CYCLES` + 10 → one `frame_err`. A subsequent full 1C frame decodes correctly.
- 3-cycle low glitch on `ps2_clk` (shorter than `FILTER_LEN`) while idle → no state change. Full pause sequence E1 14 77 E1 F0 14 F0 77 → one strobe with `keycode` E1.

Source files
------------

// File: rtl/ps2_keycode_decoder_pkg.sv
// rtl/ps2_keycode_decoder_pkg.sv - scan-code constants and FSM state types for the PS/2 decoder
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam int         PAUSE_TAIL_LEN = 7;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_PAUSE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// rtl/ps2_keycode_decoder_if.sv - keyboard pins and decoded key-event bundle
interface ps2_keycode_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_strobe;
  logic       frame_err;

  // Keyboard side: drives the pins, observes decoded events
  modport master (
    output ps2_clk, ps2_dat,
    input  keycode, key_make, key_ext, key_strobe, frame_err
  );

  // Decoder side: reads the pins, drives decoded events
  modport slave (
    input  ps2_clk, ps2_dat,
    output keycode, key_make, key_ext, key_strobe, frame_err
  );
endinterface

// File: rtl/ps2_keycode_decoder_rx_frame.sv
// rtl/ps2_keycode_decoder_rx_frame.sv - PS/2 pin sync, clock glitch filter, frame FSM and timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             par_ok_q;
  frame_state_e     state_q, state_d;

  logic bit_event, dat_bit, timeout, stop_good;

  // Two-flop synchronizers; idle bus level is high on both lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else if (clk_sync_q[1] != filt_q) begin
      if (flt_cnt_q == FLT_MAX) begin
        filt_q    <= clk_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end else begin
      flt_cnt_q <= '0;
    end
  end

  assign bit_event = filt_q && !clk_sync_q[1] && (flt_cnt_q == FLT_MAX);
  assign dat_bit   = dat_sync_q[1];
  // A bit event in the same cycle beats an expiring timeout
  assign timeout   = (state_q != FR_IDLE) && !bit_event && (tmo_cnt_q == TMO_MAX);
  assign stop_good = dat_bit && par_ok_q;

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FR_IDLE;
    else        state_q <= state_d;
  end

  // Frame next-state: advance one step per bit event, bail to IDLE on timeout
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = FR_IDLE;
    end else if (bit_event) begin
      case (state_q)
        FR_IDLE:   if (!dat_bit) state_d = FR_DATA;
        FR_DATA:   if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
        FR_PARITY: state_d = FR_STOP;
        FR_STOP:   state_d = FR_IDLE;
        default:   state_d = FR_IDLE;
      endcase
    end
  end

  // Frame datapath: timeout counter, LSB-first shifter, parity capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_ok_q  <= 1'b0;
    end else begin
      if (state_q == FR_IDLE || bit_event || timeout) tmo_cnt_q <= '0;
      else                                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (bit_event) begin
        case (state_q)
          FR_IDLE: bit_cnt_q <= '0;
          FR_DATA: begin
            shift_q   <= {dat_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          FR_PARITY: par_ok_q <= ^{shift_q, dat_bit};
          default: ;
        endcase
      end
    end
  end

  // Frame outputs: stop-bit verdict or timeout, one cycle each
  always_comb begin
    byte_valid_o = 1'b0;
    frame_err_o  = timeout;
    if (bit_event && state_q == FR_STOP) begin
      byte_valid_o = stop_good;
      frame_err_o  = !stop_good;
    end
  end

  assign rx_byte_o = shift_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// rtl/ps2_keycode_decoder.sv - scan-code sequence decoder producing held key events and strobes
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_keycode_decoder_if.slave    bus
);

  localparam logic [2:0] PAUSE_LAST = 3'(PAUSE_TAIL_LEN - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  seq_state_e seq_q, seq_d;
  logic       ext_pend_q, brk_pend_q;
  logic [2:0] pause_cnt_q;
  logic [7:0] keycode_q;
  logic       key_make_q, key_ext_q, key_strobe_q, frame_err_q;

  logic       emit;
  logic [7:0] emit_code;
  logic       emit_make, emit_ext;
  logic       is_prefix;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_frame (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_i    (bus.ps2_clk),
    .ps2_dat_i    (bus.ps2_dat),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK) || (rx_byte == SC_PAUSE);

  // Sequence state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) seq_q <= SEQ_IDLE;
    else        seq_q <= seq_d;
  end

  // Sequence next-state: E1 opens the pause tail, the 7th tail byte closes it
  always_comb begin
    seq_d = seq_q;
    if (rx_err) begin
      seq_d = SEQ_IDLE;
    end else if (rx_valid) begin
      case (seq_q)
        SEQ_IDLE:  if (rx_byte == SC_PAUSE) seq_d = SEQ_PAUSE;
        SEQ_PAUSE: if (pause_cnt_q == PAUSE_LAST) seq_d = SEQ_IDLE;
        default:   seq_d = SEQ_IDLE;
      endcase
    end
  end

  // Sequence outputs: decide whether this byte completes a key event
  always_comb begin
    emit      = 1'b0;
    emit_code = rx_byte;
    emit_make = !brk_pend_q;
    emit_ext  = ext_pend_q;
    if (rx_valid) begin
      case (seq_q)
        SEQ_IDLE: emit = !is_prefix;
        SEQ_PAUSE: begin
          if (pause_cnt_q == PAUSE_LAST) begin
            emit      = 1'b1;
            emit_code = SC_PAUSE;
            emit_make = 1'b1;
            emit_ext  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix flags and pause-tail counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      pause_cnt_q <= '0;
    end else if (rx_err) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      pause_cnt_q <= '0;
    end else if (rx_valid) begin
      if (seq_q == SEQ_PAUSE) begin
        pause_cnt_q <= (pause_cnt_q == PAUSE_LAST) ? 3'd0 : pause_cnt_q + 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_pend_q <= 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_pend_q <= 1'b1;
      end else begin
        ext_pend_q  <= 1'b0;
        brk_pend_q  <= 1'b0;
        pause_cnt_q <= '0;
      end
    end
  end

  // Held key event registers and single-cycle strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keycode_q    <= '0;
      key_make_q   <= 1'b0;
      key_ext_q    <= 1'b0;
      key_strobe_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      key_strobe_q <= emit;
      frame_err_q  <= rx_err;
      if (emit) begin
        keycode_q  <= emit_code;
        key_make_q <= emit_make;
        key_ext_q  <= emit_ext;
      end
    end
  end

  assign bus.keycode    = keycode_q;
  assign bus.key_make   = key_make_q;
  assign bus.key_ext    = key_ext_q;
  assign bus.key_strobe = key_strobe_q;
  assign bus.frame_err  = frame_err_q;

endmodule
